// File: rtl/spi_flash_responder.sv
// spi_flash_responder: byte-wide SPI-style flash responder backed by a
// MEM_WORDS x 32-bit register array. Frame = command, 3 address bytes
// (MSB first), 4 data bytes (MSB first). READ data is returned with zero
// wait states during byte positions 4..7; WRITE commits on byte 7.
// Optional feature macro: SPI_FLASH_WP_EN adds an active-low write-protect
// input s_wp_n that blocks the commit of a WRITE and flags err.
module spi_flash_responder #(
    parameter int MEM_WORDS = 256,
    parameter int IDX_W     = 8
) (
    input  logic       s_clk,
    input  logic       s_reset,
    input  logic       s_css,
    input  logic [7:0] s_mosi,
`ifdef SPI_FLASH_WP_EN
    input  logic       s_wp_n,
`endif
    output logic [7:0] s_miso,
    output logic       busy,
    output logic       wr_done,
    output logic       err
);

    localparam logic [7:0] CMD_READ  = 8'h01;
    localparam logic [7:0] CMD_WRITE = 8'h02;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CMD    = 3'd1,
        ADDR   = 3'd2,
        DATA   = 3'd3,
        IGNORE = 3'd4
    } state_e;

    state_e             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;      // byte position within the frame, saturates at 8
    logic [7:0]         cmd_q, cmd_d;
    logic [IDX_W-1:0]   idx_q, idx_d;      // address bytes shifted in; only low IDX_W bits kept
    logic [23:0]        data_q, data_d;    // first three write-data bytes
    logic [23:0]        rd_q, rd_d;        // remaining read bytes after the MSB is sent
    logic [7:0]         s_miso_q, s_miso_d;
    logic               wr_done_q, wr_done_d;
    logic               err_q, err_d;

    logic               mem_we;
    logic [31:0]        mem_wdata;
    logic [31:0]        mem_q [MEM_WORDS];

    logic               wp_block;

`ifdef SPI_FLASH_WP_EN
    assign wp_block = ~s_wp_n;
`else
    assign wp_block = 1'b0;
`endif

    assign s_miso  = s_miso_q;
    assign busy    = (state_q != IDLE);
    assign wr_done = wr_done_q;
    assign err     = err_q;

    // Next-state, byte capture, read-data sequencing and write commit.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cmd_d     = cmd_q;
        idx_d     = idx_q;
        data_d    = data_q;
        rd_d      = rd_q;
        s_miso_d  = 8'h00;
        wr_done_d = 1'b0;
        err_d     = err_q;
        mem_we    = 1'b0;
        mem_wdata = {data_q, s_mosi};

        if (s_css) begin
            // Deselect always ends the frame; a partial write never commits.
            state_d = IDLE;
            cnt_d   = 4'd0;
        end else begin
            cnt_d = (cnt_q == 4'd8) ? 4'd8 : cnt_q + 4'd1;
            case (state_q)
                IDLE: begin
                    cmd_d   = s_mosi;
                    state_d = CMD;
                end
                CMD: begin
                    idx_d = IDX_W'({idx_q, s_mosi});
                    if (cmd_q == CMD_READ || cmd_q == CMD_WRITE) begin
                        state_d = ADDR;
                    end else begin
                        state_d = IGNORE;
                        err_d   = 1'b1;
                    end
                end
                ADDR: begin
                    idx_d = IDX_W'({idx_q, s_mosi});
                    if (cnt_q == 4'd3) begin
                        state_d = DATA;
                        if (cmd_q == CMD_READ) begin
                            // Full index is known on this edge, so the MSB goes out now.
                            rd_d     = mem_q[idx_d][23:0];
                            s_miso_d = mem_q[idx_d][31:24];
                        end
                    end
                end
                DATA: begin
                    data_d = {data_q[15:0], s_mosi};
                    if (cmd_q == CMD_READ) begin
                        case (cnt_q)
                            4'd4:    s_miso_d = rd_q[23:16];
                            4'd5:    s_miso_d = rd_q[15:8];
                            4'd6:    s_miso_d = rd_q[7:0];
                            default: s_miso_d = 8'h00;
                        endcase
                    end
                    if (cnt_q == 4'd7) begin
                        state_d = IGNORE;
                        if (cmd_q == CMD_WRITE) begin
                            if (wp_block) begin
                                err_d = 1'b1;
                            end else begin
                                mem_we    = ~s_reset;
                                wr_done_d = 1'b1;
                            end
                        end
                    end
                end
                default: ;  // IGNORE: swallow bytes until deselect
            endcase
        end
    end

    // Control/state registers; reset wins over everything, memory untouched.
    always_ff @(posedge s_clk) begin
        if (s_reset) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            cmd_q     <= 8'h00;
            idx_q     <= '0;
            data_q    <= 24'h0;
            rd_q      <= 24'h0;
            s_miso_q  <= 8'h00;
            wr_done_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cmd_q     <= cmd_d;
            idx_q     <= idx_d;
            data_q    <= data_d;
            rd_q      <= rd_d;
            s_miso_q  <= s_miso_d;
            wr_done_q <= wr_done_d;
            err_q     <= err_d;
        end
    end

    // Storage array: no reset so contents survive s_reset.
    always_ff @(posedge s_clk) begin
        if (mem_we) begin
            mem_q[idx_q] <= mem_wdata;
        end
    end

endmodule

// File: tb/tb_spi_flash_responder.sv
// Directed bench for spi_flash_responder. Build with +define+SPI_FLASH_WP_EN
// to include the write-protect case.
module tb_spi_flash_responder;

    logic       s_clk = 1'b0;
    logic       s_reset;
    logic       s_css;
    logic [7:0] s_mosi;
`ifdef SPI_FLASH_WP_EN
    logic       s_wp_n;
`endif
    logic [7:0] s_miso;
    logic       busy;
    logic       wr_done;
    logic       err;

    int checks = 0;
    int errors = 0;

    spi_flash_responder #(.MEM_WORDS(256), .IDX_W(8)) dut (
        .s_clk   (s_clk),
        .s_reset (s_reset),
        .s_css   (s_css),
        .s_mosi  (s_mosi),
`ifdef SPI_FLASH_WP_EN
        .s_wp_n  (s_wp_n),
`endif
        .s_miso  (s_miso),
        .busy    (busy),
        .wr_done (wr_done),
        .err     (err)
    );

    always #5 s_clk = ~s_clk;

    initial begin
        #500000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // One byte per clock; outputs sampled 1ns after the edge.
    task automatic send(input logic [7:0] b);
        s_css  = 1'b0;
        s_mosi = b;
        @(posedge s_clk);
        #1;
    endtask

    task automatic deselect();
        s_css  = 1'b1;
        s_mosi = 8'h00;
        @(posedge s_clk);
        #1;
    endtask

    // Sends the first n bytes of a WRITE frame, then one deselect cycle.
    task automatic wr_frame(input logic [23:0] a, input logic [31:0] d, input int n,
                            input logic exp_done);
        logic [63:0] fr;
        fr = {8'h02, a, d};
        for (int i = 0; i < n; i++) begin
            send(fr[63-8*i -: 8]);
            chk("wr_busy", {31'd0, busy}, 32'd1);
            if (i < 7) chk("wr_done_early", {31'd0, wr_done}, 32'd0);
            else       chk("wr_done_pulse", {31'd0, wr_done}, {31'd0, exp_done});
        end
        deselect();
        chk("wr_done_after", {31'd0, wr_done}, 32'd0);
        chk("idle_busy", {31'd0, busy}, 32'd0);
    endtask

    // Full READ frame; s_miso shows the word during positions 4..7.
    task automatic rd_frame(input logic [23:0] a, input logic [31:0] exp);
        logic [63:0] fr;
        logic [7:0]  e;
        fr = {8'h01, a, 32'h5A5A_5A5A};
        for (int i = 0; i < 8; i++) begin
            send(fr[63-8*i -: 8]);
            case (i)
                3:       e = exp[31:24];
                4:       e = exp[23:16];
                5:       e = exp[15:8];
                6:       e = exp[7:0];
                default: e = 8'h00;
            endcase
            chk($sformatf("rd_miso_%0d", i), {24'd0, s_miso}, {24'd0, e});
        end
        deselect();
        chk("rd_miso_idle", {24'd0, s_miso}, 32'd0);
    endtask

    initial begin
        logic [63:0] fr;
        s_reset = 1'b1;
        s_css   = 1'b1;
        s_mosi  = 8'h00;
`ifdef SPI_FLASH_WP_EN
        s_wp_n  = 1'b1;
`endif
        repeat (2) @(posedge s_clk);
        #1;
        chk("rst_miso", {24'd0, s_miso}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_wr_done", {31'd0, wr_done}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        s_reset = 1'b0;
        deselect();

        // Basic write then back-to-back read of the new data
        wr_frame(24'h000005, 32'hDEAD_BEEF, 8, 1'b1);
        rd_frame(24'h000005, 32'hDEAD_BEEF);
        chk("err_clean", {31'd0, err}, 32'd0);

        // Bad command: err sticky, miso quiet, memory intact
        fr = {8'h07, 24'h000005, 32'h0102_0304};
        for (int i = 0; i < 8; i++) begin
            send(fr[63-8*i -: 8]);
            chk("bad_miso", {24'd0, s_miso}, 32'd0);
            chk("bad_wr_done", {31'd0, wr_done}, 32'd0);
        end
        chk("bad_err", {31'd0, err}, 32'd1);
        deselect();
        chk("bad_err_sticky", {31'd0, err}, 32'd1);
        rd_frame(24'h000005, 32'hDEAD_BEEF);

        // Aborted write after byte 5 leaves the old word
        wr_frame(24'h000003, 32'h1122_3344, 8, 1'b1);
        wr_frame(24'h000003, 32'h5566_7788, 6, 1'b0);
        rd_frame(24'h000003, 32'h1122_3344);

        // Address wrap modulo MEM_WORDS
        wr_frame(24'h000105, 32'hCAFE_F00D, 8, 1'b1);
        rd_frame(24'h000005, 32'hCAFE_F00D);
        rd_frame(24'h000003, 32'h1122_3344);

        // Reset at byte 6 of a write
        wr_frame(24'h000007, 32'hA5A5_A5A5, 8, 1'b1);
        fr = {8'h02, 24'h000007, 32'h1234_5678};
        for (int i = 0; i < 6; i++) send(fr[63-8*i -: 8]);
        s_reset = 1'b1;
        send(fr[15:8]);
        chk("mid_rst_miso", {24'd0, s_miso}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_wr_done", {31'd0, wr_done}, 32'd0);
        chk("mid_rst_err", {31'd0, err}, 32'd0);
        s_reset = 1'b0;
        deselect();
        chk("post_rst_wr_done", {31'd0, wr_done}, 32'd0);
        rd_frame(24'h000007, 32'hA5A5_A5A5);
        wr_frame(24'h000009, 32'h0BAD_F00D, 8, 1'b1);
        rd_frame(24'h000009, 32'h0BAD_F00D);

`ifdef SPI_FLASH_WP_EN
        // Write protect blocks the commit and flags err
        s_wp_n = 1'b0;
        wr_frame(24'h000005, 32'h7777_7777, 8, 1'b0);
        chk("wp_err", {31'd0, err}, 32'd1);
        s_wp_n = 1'b1;
        rd_frame(24'h000005, 32'hCAFE_F00D);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
